fir_mac_seq: RTL and testbench
==============================

// Module: fir_mac_seq
// PURPOSE
//  Time-multiplexed, parametrised FIR MAC engine: one shared multiplier serves NUM_TAPS taps.
//  Holds the sample delay line and sequences coefficient reads from the external coefficient memory.
//  Accumulates at full precision, then rounds and saturates the result.
//  Sits between the input sample source and the filter output register; it supersedes the fixed 3-tap MAC.
// PARAMETERS
//  NUM_TAPS  3   number of taps (>=2); ADDR_W = max(1,$clog2(NUM_TAPS)) is derived
//  DATA_W    3   signed input sample width
//  COEF_W    16  signed coefficient width
//  ACC_W     24  accumulator width; must be >= DATA_W+COEF_W+$clog2(NUM_TAPS)
//  OUT_W     16  signed output width
//  SHIFT     0   arithmetic right shift applied before saturation (0..ACC_W-OUT_W)
// PORTS
//  iClk_12M    in   1       system clock, all state on rising edge
//  iRst        in   1       asynchronous reset, active-high
//  iClear      in   1       sync clear: zero delay line/acc, abort to IDLE
//  iInValid    in   1       new sample present on iInData
//  iInData     in   DATA_W  signed sample
//  oReady      out  1       1 in IDLE: sample accepted when iInValid&oReady
//  oCoeffRd    out  1       coefficient read strobe
//  oCoeffAddr  out  ADDR_W  coefficient index (tap number)
//  iCoeff      in   COEF_W  signed coefficient; valid 1 cycle after the oCoeffRd cycle
//  oValid      out  1       1-cycle pulse: oData/oSat valid
//  oData       out  OUT_W   rounded, saturated filter output (held until next oValid)
//  oSat        out  1       oData was clipped (qualified by oValid)
//  oDrop       out  1       1-cycle pulse: iInValid while !oReady, sample discarded
// BEHAVIOUR
//  Reset (iRst=1, async): state IDLE, delay line 0, acc 0, tap counter 0, oReady=1, oCoeffRd=0,
//   oCoeffAddr=0, oValid=0, oData=0, oSat=0, oDrop=0.
//  Delay line d[0..NUM_TAPS-1], d[k]=x[n-k]; on accept: d[0]<=iInData, d[k]<=d[k-1]; else held.
//  FSM: IDLE -> RUN on accept (acc<=0, tap<=0). RUN lasts NUM_TAPS cycles: oCoeffRd=1, oCoeffAddr=tap,
//   tap increments; after tap=NUM_TAPS-1 -> DRAIN. DRAIN: 1 cycle, oCoeffRd=0, final accumulate -> IDLE.
//  Accumulate: in the cycle after each read of tap t, acc <= acc + sext(d[t]*iCoeff) (product DATA_W+COEF_W).
//   This covers RUN cycles 2..NUM_TAPS and DRAIN. Accumulator wraps mod 2^ACC_W (sizing rule prevents it).
//  Output stage, at DRAIN exit: r = (SHIFT>0) ? (accFinal + 2^(SHIFT-1)) >>> SHIFT : accFinal.
//   Clip r to [-2^(OUT_W-1), 2^(OUT_W-1)-1]; oData<=clipped r; oSat<=(clipped r != r); oValid<=1 for 1 cycle.
//  Latency: sample accepted at edge 0 -> oValid high during cycle NUM_TAPS+2 (cycle 5 for defaults).
//   oReady=1 again in that same cycle; max throughput 1 sample per NUM_TAPS+2 cycles.
//  Accept and oValid in the same cycle is legal; the new RUN starts while the old result is presented.
//  iInValid when !oReady: sample ignored, delay line unchanged, oDrop=1 next cycle.
//  iClear has priority over accept: delay line and acc zeroed, state->IDLE, tap=0, no oValid for aborted op;
//   oData/oSat retain their last values.
//  Async iRst mid-RUN/DRAIN: immediate return to reset values; no partial result emitted.
//  oCoeffRd never asserted outside RUN; oCoeffAddr=0 when not in RUN.
// TESTING (defaults unless noted; coefficient model returns mem[addr] one cycle after oCoeffRd)
//  Impulse: mem={1,2,3}; samples 1,0,0,0 spaced 5 cycles -> oData 1,2,3,0; oSat=0; oValid exactly 5 cycles after each accept.
//  Saturation: mem={32767,32767,32767}; samples -4,-4,-4 -> acc -131068,-262136,-393204; oData=-32768 each time, oSat=1.
//   Repeat with mem={-32768,-32768,-32768} -> oData=32767 (first is 131072), oSat=1.
//  Rounding: SHIFT=2, mem={3,0,0}; sample 1 -> oData=1; sample -1 (after clear) -> oData=-1; sample 2 -> oData=2 (acc 6).
//  Back-pressure: iInValid held high 12 cycles -> exactly 3 accepts (cycles 0,5,10); oDrop pulses otherwise;
//   delay line shows only accepted samples.
//  Abort: iClear in RUN cycle 2 -> no oValid; oCoeffRd low next cycle; next sample 1 with mem={1,2,3} -> oData=1.
//  Reset: iRst pulsed asynchronously mid-RUN -> all outputs reset values within the same cycle; oReady=1 after release.

Source files
------------

// File: rtl/fir_mac_seq.sv
// fir_mac_seq: time-multiplexed FIR MAC, one multiplier shared by all taps.
// Coefficients are fetched tap by tap; the full-precision sum is rounded and clipped.
module fir_mac_seq #(
  parameter int NUM_TAPS = 3,
  parameter int DATA_W   = 3,
  parameter int COEF_W   = 16,
  parameter int ACC_W    = 24,
  parameter int OUT_W    = 16,
  parameter int SHIFT    = 0,
  localparam int ADDR_W  = (NUM_TAPS > 2) ? $clog2(NUM_TAPS) : 1
) (
  input  logic                     iClk_12M,
  input  logic                     iRst,
  input  logic                     iClear,
  input  logic                     iInValid,
  input  logic signed [DATA_W-1:0] iInData,
  output logic                     oReady,
  output logic                     oCoeffRd,
  output logic [ADDR_W-1:0]        oCoeffAddr,
  input  logic signed [COEF_W-1:0] iCoeff,
  output logic                     oValid,
  output logic signed [OUT_W-1:0]  oData,
  output logic                     oSat,
  output logic                     oDrop
);

  localparam int PROD_W = DATA_W + COEF_W;
  localparam logic [ACC_W:0] RND = ((ACC_W + 1)'(1) << SHIFT) >> 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t state;
  state_t state_nx;

  logic [ADDR_W-1:0]        tap;
  logic [ADDR_W-1:0]        tap_rd;
  logic                     rd_q;
  logic signed [DATA_W-1:0] dl [NUM_TAPS];
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  acc_nx;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W:0]    rnd_sum;
  logic signed [ACC_W:0]    shifted;
  logic signed [OUT_W-1:0]  clip;
  logic                     fits;
  logic                     last_tap;
  logic                     accept;
  logic                     finish;

  assign last_tap = (tap == ADDR_W'(NUM_TAPS - 1));
  assign accept   = iInValid & oReady & ~iClear;
  assign finish   = (state == DRAIN) & ~iClear;

  // shared multiplier: coefficient read last cycle times its delay-line tap
  always_comb begin
    prod    = PROD_W'(dl[tap_rd]) * PROD_W'(iCoeff);
    acc_nx  = acc + {{(ACC_W - PROD_W){prod[PROD_W-1]}}, prod};
    rnd_sum = {acc_nx[ACC_W-1], acc_nx} + RND;
    shifted = rnd_sum >>> SHIFT;
    fits    = (&shifted[ACC_W:OUT_W-1]) | ~(|shifted[ACC_W:OUT_W-1]);
    clip    = shifted[OUT_W-1:0];
    if (!fits)
      clip = shifted[ACC_W] ? {1'b1, {(OUT_W-1){1'b0}}}
                            : {1'b0, {(OUT_W-1){1'b1}}};
  end

  // state register
  always_ff @(posedge iClk_12M or posedge iRst) begin
    if (iRst) state <= IDLE;
    else      state <= state_nx;
  end

  // next-state: clear aborts from any state
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (accept)   state_nx = RUN;
      RUN:     if (last_tap) state_nx = DRAIN;
      DRAIN:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (iClear) state_nx = IDLE;
  end

  // handshake and coefficient-read outputs
  always_comb begin
    oReady     = (state == IDLE);
    oCoeffRd   = (state == RUN);
    oCoeffAddr = (state == RUN) ? tap : '0;
  end

  // delay line, tap counter and accumulator
  always_ff @(posedge iClk_12M or posedge iRst) begin
    if (iRst) begin
      for (int k = 0; k < NUM_TAPS; k++) dl[k] <= '0;
      acc    <= '0;
      tap    <= '0;
      tap_rd <= '0;
      rd_q   <= 1'b0;
    end else if (iClear) begin
      for (int k = 0; k < NUM_TAPS; k++) dl[k] <= '0;
      acc    <= '0;
      tap    <= '0;
      tap_rd <= '0;
      rd_q   <= 1'b0;
    end else begin
      rd_q   <= oCoeffRd;
      tap_rd <= tap;
      if (accept) begin
        dl[0] <= iInData;
        for (int k = 1; k < NUM_TAPS; k++) dl[k] <= dl[k-1];
        acc <= '0;
        tap <= '0;
      end else begin
        if (rd_q) acc <= acc_nx;
        if (state == RUN) tap <= last_tap ? '0 : tap + 1'b1;
      end
    end
  end

  // result register and drop flag
  always_ff @(posedge iClk_12M or posedge iRst) begin
    if (iRst) begin
      oValid <= 1'b0;
      oData  <= '0;
      oSat   <= 1'b0;
      oDrop  <= 1'b0;
    end else begin
      oDrop  <= iInValid & ~oReady;
      oValid <= finish;
      if (finish) begin
        oData <= clip;
        oSat  <= ~fits;
      end
    end
  end

endmodule

// File: tb/tb_fir_mac_seq.sv
// tb_fir_mac_seq: table vectors, corner sequences and random traffic
// checked against a sum-of-products reference model.
module tb_fir_mac_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst, clear, in_valid;
  logic signed [2:0]  in_data;
  logic               ready, coeff_rd, valid, sat, drop;
  logic [1:0]         coeff_addr;
  logic signed [15:0] coeff = '0;
  logic signed [15:0] data;
  logic signed [15:0] mem [3];

  logic               clear2, in_valid2;
  logic signed [2:0]  in_data2;
  logic               ready2, coeff_rd2, valid2, sat2, drop2;
  logic [1:0]         coeff_addr2;
  logic signed [15:0] coeff2 = '0;
  logic signed [15:0] data2;
  logic signed [15:0] mem2 [3];

  fir_mac_seq dut (
    .iClk_12M(clk), .iRst(rst), .iClear(clear),
    .iInValid(in_valid), .iInData(in_data), .oReady(ready),
    .oCoeffRd(coeff_rd), .oCoeffAddr(coeff_addr), .iCoeff(coeff),
    .oValid(valid), .oData(data), .oSat(sat), .oDrop(drop)
  );

  fir_mac_seq #(.SHIFT(2)) dut2 (
    .iClk_12M(clk), .iRst(rst), .iClear(clear2),
    .iInValid(in_valid2), .iInData(in_data2), .oReady(ready2),
    .oCoeffRd(coeff_rd2), .oCoeffAddr(coeff_addr2), .iCoeff(coeff2),
    .oValid(valid2), .oData(data2), .oSat(sat2), .oDrop(drop2)
  );

  // coefficient memories: data one cycle after the read strobe
  always @(posedge clk) if (coeff_rd) coeff <= mem[coeff_addr];
  always @(posedge clk) if (coeff_rd2) coeff2 <= mem2[coeff_addr2];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // reference model state
  int     hist [3];
  int     busy = 0;
  int     out_cd = 0;
  bit     drop_exp = 0;
  longint pend_data = 0;
  bit     pend_sat = 0;
  longint hold_data = 0;
  int     got_cnt = 0;
  longint got_data = 0;
  bit     got_sat = 0;
  int     dut_acc = 0;

  function automatic void fold(input longint y, input int sh,
                               output longint d, output bit s);
    longint r;
    r = (sh > 0) ? ((y + (longint'(1) <<< (sh - 1))) >>> sh) : y;
    s = 1'b1;
    if (r > 32767)       d = 32767;
    else if (r < -32768) d = -32768;
    else begin d = r; s = 1'b0; end
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) hist[k] = 0;
    busy = 0; out_cd = 0; drop_exp = 0; hold_data = 0;
  endtask

  // one cycle: check outputs against the model, then drive and step the model
  task automatic tick(input bit v, input int x, input bit clr);
    longint y;
    bit     acc_ok;
    @(negedge clk);
    if (out_cd == 1) hold_data = pend_data;
    chk("ready", ready, busy == 0);
    chk("coeff_rd", coeff_rd, busy >= 2);
    chk("coeff_addr", coeff_addr, (busy >= 2) ? 4 - busy : 0);
    chk("valid", valid, out_cd == 1);
    chk("drop", drop, drop_exp);
    chk("data", longint'(data), hold_data);
    if (out_cd == 1) begin
      chk("sat", sat, pend_sat);
      got_cnt++;
      got_data = longint'(data);
      got_sat = sat;
    end
    if (v && ready && !clr) dut_acc++;
    in_valid = v;
    in_data  = x[2:0];
    clear    = clr;
    acc_ok   = v && (busy == 0) && !clr;
    drop_exp = v && (busy != 0);
    if (busy > 0) busy--;
    if (out_cd > 0) out_cd--;
    if (clr) begin
      for (int k = 0; k < 3; k++) hist[k] = 0;
      busy = 0; out_cd = 0;
    end else if (acc_ok) begin
      hist[2] = hist[1]; hist[1] = hist[0]; hist[0] = x;
      y = 0;
      for (int k = 0; k < 3; k++) y += longint'(mem[k]) * hist[k];
      fold(y, 0, pend_data, pend_sat);
      busy = 4; out_cd = 5;
    end
  endtask

  typedef struct {
    bit clr; int m0; int m1; int m2; int x; int exp_d; bit exp_s;
  } vec_t;

  function automatic vec_t mk(bit c, int a, int b, int d, int x, int e, bit s);
    mk.clr = c; mk.m0 = a; mk.m1 = b; mk.m2 = d;
    mk.x = x; mk.exp_d = e; mk.exp_s = s;
  endfunction

  vec_t tbl [$];

  task automatic run2(input bit clr, input int x, input int exp_d, input bit exp_s);
    int n;
    if (clr) begin
      @(negedge clk); clear2 = 1'b1;
      @(negedge clk); clear2 = 1'b0;
    end
    @(negedge clk);
    chk("r_ready", ready2, 1);
    in_valid2 = 1'b1; in_data2 = x[2:0];
    @(negedge clk);
    in_valid2 = 1'b0;
    n = 0;
    while (!valid2 && n < 10) begin @(negedge clk); n++; end
    chk("r_latency", n, 4);
    chk("r_data", longint'(data2), exp_d);
    chk("r_sat", sat2, exp_s);
  endtask

  initial begin
    int n0, a0;
    rst = 1'b1; clear = 1'b0; in_valid = 1'b0; in_data = '0;
    clear2 = 1'b0; in_valid2 = 1'b0; in_data2 = '0;
    for (int k = 0; k < 3; k++) begin mem[k] = '0; mem2[k] = '0; end
    model_reset();
    #1;
    chk("rst_ready", ready, 1);
    chk("rst_coeff_rd", coeff_rd, 0);
    chk("rst_addr", coeff_addr, 0);
    chk("rst_valid", valid, 0);
    chk("rst_data", longint'(data), 0);
    chk("rst_sat", sat, 0);
    chk("rst_drop", drop, 0);
    @(negedge clk); rst = 1'b0;

    tbl.push_back(mk(1, 1, 2, 3, 1, 1, 0));
    tbl.push_back(mk(0, 1, 2, 3, 0, 2, 0));
    tbl.push_back(mk(0, 1, 2, 3, 0, 3, 0));
    tbl.push_back(mk(0, 1, 2, 3, 0, 0, 0));
    tbl.push_back(mk(1, 32767, 32767, 32767, -4, -32768, 1));
    tbl.push_back(mk(0, 32767, 32767, 32767, -4, -32768, 1));
    tbl.push_back(mk(0, 32767, 32767, 32767, -4, -32768, 1));
    tbl.push_back(mk(1, -32768, -32768, -32768, -4, 32767, 1));
    tbl.push_back(mk(0, -32768, -32768, -32768, -4, 32767, 1));
    tbl.push_back(mk(0, -32768, -32768, -32768, -4, 32767, 1));
    tbl.push_back(mk(1, 100, -200, 300, 3, 300, 0));
    tbl.push_back(mk(0, 100, -200, 300, -2, -800, 0));
    tbl.push_back(mk(0, 100, -200, 300, 1, 1400, 0));
    tbl.push_back(mk(1, 32767, 0, 0, 1, 32767, 0));
    tbl.push_back(mk(1, -8192, 0, 0, -4, 32767, 1));
    tbl.push_back(mk(1, 8192, 0, 0, -4, -32768, 0));

    foreach (tbl[i]) begin
      if (tbl[i].clr) tick(0, 0, 1);
      mem[0] = 16'(tbl[i].m0); mem[1] = 16'(tbl[i].m1); mem[2] = 16'(tbl[i].m2);
      n0 = got_cnt;
      tick(1, tbl[i].x, 0);
      repeat (5) tick(0, 0, 0);
      chk("tbl_count", got_cnt - n0, 1);
      chk("tbl_data", got_data, tbl[i].exp_d);
      chk("tbl_sat", got_sat, tbl[i].exp_s);
    end

    // back-pressure: valid held for 12 cycles
    tick(0, 0, 1);
    mem[0] = 16'sd1; mem[1] = 16'sd2; mem[2] = 16'sd3;
    a0 = dut_acc;
    repeat (12) tick(1, int'($urandom_range(0, 7)) - 4, 0);
    chk("bp_accepts", dut_acc - a0, 3);
    repeat (6) tick(0, 0, 0);

    // abort in RUN cycle 2
    tick(0, 0, 1);
    n0 = got_cnt;
    tick(1, 2, 0);
    tick(0, 0, 0);
    tick(0, 0, 1);
    repeat (6) tick(0, 0, 0);
    chk("abort_no_valid", got_cnt - n0, 0);
    tick(1, 1, 0);
    repeat (5) tick(0, 0, 0);
    chk("abort_next", got_data, 1);

    // rounding with SHIFT=2
    mem2[0] = 16'sd3; mem2[1] = 16'sd0; mem2[2] = 16'sd0;
    run2(1, 1, 1, 0);
    run2(1, -1, -1, 0);
    run2(0, 2, 2, 0);
    mem2[0] = -16'sd32768;
    run2(1, -4, 32767, 1);

    // asynchronous reset in the middle of RUN
    tick(1, 3, 0);
    tick(0, 0, 0);
    tick(0, 0, 0);
    #2 rst = 1'b1;
    #1;
    chk("arst_ready", ready, 1);
    chk("arst_coeff_rd", coeff_rd, 0);
    chk("arst_addr", coeff_addr, 0);
    chk("arst_valid", valid, 0);
    chk("arst_data", longint'(data), 0);
    chk("arst_sat", sat, 0);
    chk("arst_drop", drop, 0);
    in_valid = 1'b0;
    @(negedge clk); rst = 1'b0;
    model_reset();
    n0 = got_cnt;
    tick(0, 0, 0);
    tick(1, 1, 0);
    repeat (5) tick(0, 0, 0);
    chk("arst_count", got_cnt - n0, 1);
    chk("arst_next", got_data, 1);

    // random traffic
    tick(0, 0, 1);
    for (int k = 0; k < 3; k++) mem[k] = 16'($urandom_range(0, 65535));
    repeat (400)
      tick(1'($urandom_range(0, 1)), int'($urandom_range(0, 7)) - 4,
           $urandom_range(0, 39) == 0);
    repeat (6) tick(0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
